sys_clk_timer_servicer: RTL
===========================

// Module: sys_clk_timer_servicer
// PURPOSE
//  Avalon-MM master (initiator) that drives the 16-bit sys_clk interval timer slave. It
//  programs the period, starts the timer in continuous mode and services each timeout IRQ.
//  It counts ticks and optionally captures a counter snapshot per tick.
//  Sits between the sopc timer slave and hardware consumers of a periodic tick; no CPU involved.
// PARAMETERS
//  PERIOD       600000  timer period in clk cycles (>=2); the block programs PERIOD-1 into period_h:period_l
//  SNAPSHOT_EN  1       1 = snapshot write + two reads after every serviced tick; 0 = skip
// PORTS
//  clk            in   1   system clock
//  reset          in   1   async active-high reset
//  enable         in   1   level; 1 = run timer, 0 = stop timer
//  tick_clear     in   1   sync pulse; zeroes tick_count
//  irq            in   1   timer slave irq
//  readdata       in   16  timer slave readdata (registered in slave)
//  address        out  3   timer slave address
//  chipselect     out  1   timer slave chipselect
//  write_n        out  1   timer slave write_n, active low
//  writedata      out  16  timer slave writedata
//  busy           out  1   FSM not in IDLE
//  tick_pulse     out  1   one-cycle pulse per serviced timeout
//  tick_count     out  32  serviced timeouts, wraps 0xFFFFFFFF->0
//  snapshot       out  32  last captured counter value {snap_h,snap_l}
//  snapshot_valid out  1   one-cycle pulse when snapshot is updated
// BEHAVIOUR
//  - Reset: all outputs registered. chipselect=0, write_n=1, address=0, writedata=0, busy=0,
//    tick_pulse=0, tick_count=0, snapshot=0, snapshot_valid=0. FSM=IDLE.
//  - Bus: each access holds chipselect=1 for exactly one cycle; no waitrequest.
//    Write = write_n 0. Read = write_n 1.
//    Read latency: readdata is sampled on the 2nd rising edge after the edge that launched the address.
//  - FSM: IDLE -> WR_PL -> WR_PH -> WR_CTRL -> RUN; RUN -> CLR_STS -> [SNAP_WR -> RD_L_A -> RD_L_W
//    -> RD_H_A -> RD_H_W] -> TICK -> RUN; RUN -> WR_STOP -> IDLE.
//  - IDLE: waits for enable=1.
//  - WR_PL: writes addr 2, data (PERIOD-1)[15:0].
//  - WR_PH: writes addr 3, data (PERIOD-1)[31:16].
//  - WR_CTRL: writes addr 1, data 0x0007 (ITO|CONT|START).
//  - RUN: irq=1 -> CLR_STS; else enable=0 -> WR_STOP. irq takes priority.
//  - CLR_STS: writes addr 0, data 0. This clears TO, so irq is low in the next cycle.
//  - SNAP_WR: writes addr 4 (any data) to latch the counter.
//  - RD_L_A / RD_L_W: read addr 4; low half captured in RD_L_W.
//  - RD_H_A / RD_H_W: read addr 5; high half captured in RD_H_W.
//  - TICK: tick_pulse=1, tick_count+=1, snapshot_valid=SNAPSHOT_EN. Then return to RUN.
//  - SNAPSHOT_EN=0: CLR_STS goes directly to TICK.
//  - WR_STOP: writes addr 1, data 0x0008 (STOP, ITO=0), then IDLE.
//  - enable falling in any state other than RUN: the in-flight sequence completes and the
//    stop is issued from RUN. enable=0 in WR_PL..WR_CTRL still completes the start, then stops.
//  - enable=1 again in IDLE: full reprogram sequence.
//  - tick_clear and TICK in the same cycle: tick_count=1.
//  - Multiple timeouts between clears merge in the slave's TO bit; they count as one tick.
//  - Async reset mid-access drops chipselect immediately; the slave is reprogrammed on next enable.
// TESTING
//  1 PERIOD=600000, reset, enable=1 -> three consecutive writes: a2/0x27BF, a3/0x0009, a1/0x0007; busy=1.
//  2 Slave model raises irq -> next cycle write a0/0x0000; tick_pulse once; tick_count 0->1; 100 irqs -> 100.
//  3 Slave counter=0x00012345 at SNAP_WR -> snapshot=0x00012345 with snapshot_valid; readdata
//    sampled at exact latency (slave model drives garbage on other cycles).
//  4 enable=0 while in RUN -> write a1/0x0008, then IDLE, busy=0; later irq ignored; re-enable reprograms.
//  5 enable=0 during RD_L_A -> snapshot sequence and TICK complete, then a1/0x0008; tick_count +1 only.
//  6 Async reset during WR_PH, then tick_clear coincident with TICK
//    -> reset: chipselect=0 same cycle, tick_count=0, FSM=IDLE.
//    -> tick_clear with TICK: tick_count=1.

Source files
------------

// File: rtl/sys_clk_timer_servicer.sv
// Avalon-MM initiator that programs the 16-bit sys_clk interval timer for continuous
// timeouts, services each timeout IRQ, counts ticks and optionally snapshots the counter.
module sys_clk_timer_servicer #(
  parameter int unsigned PERIOD      = 600000,
  parameter bit          SNAPSHOT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        tick_clear,
  input  logic        irq,
  input  logic [15:0] readdata,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [15:0] writedata,
  output logic        busy,
  output logic        tick_pulse,
  output logic [31:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snapshot_valid
);

  localparam logic [31:0] PRD_M1 = 32'(PERIOD - 1);

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PRD_L  = 3'd2;
  localparam logic [2:0] A_PRD_H  = 3'd3;
  localparam logic [2:0] A_SNAP_L = 3'd4;
  localparam logic [2:0] A_SNAP_H = 3'd5;

  localparam logic [15:0] CTRL_START = 16'h0007;  // ITO | CONT | START
  localparam logic [15:0] CTRL_STOP  = 16'h0008;  // STOP, ITO cleared

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_STS, SNAP_WR,
    RD_L_A, RD_L_W, RD_H_A, RD_H_W, TICK, WR_STOP
  } state_t;

  state_t      state, nxt;
  logic        b_cs, b_wn;
  logic [2:0]  b_addr;
  logic [15:0] b_wd;
  logic [15:0] snap_l;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (enable) nxt = WR_PL;
      WR_PL:   nxt = WR_PH;
      WR_PH:   nxt = WR_CTRL;
      WR_CTRL: nxt = RUN;
      RUN: begin
        if (irq)          nxt = CLR_STS;
        else if (!enable) nxt = WR_STOP;
      end
      CLR_STS: nxt = SNAPSHOT_EN ? SNAP_WR : TICK;
      SNAP_WR: nxt = RD_L_A;
      RD_L_A:  nxt = RD_L_W;
      RD_L_W:  nxt = RD_H_A;
      RD_H_A:  nxt = RD_H_W;
      RD_H_W:  nxt = TICK;
      TICK:    nxt = RUN;
      WR_STOP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Bus signals are decoded from the next state and registered, so each access
  // is presented for exactly the one cycle spent in its state.
  always_comb begin
    b_cs   = 1'b0;
    b_wn   = 1'b1;
    b_addr = 3'd0;
    b_wd   = 16'h0000;
    case (nxt)
      WR_PL:   begin b_cs = 1'b1; b_wn = 1'b0; b_addr = A_PRD_L;  b_wd = PRD_M1[15:0];  end
      WR_PH:   begin b_cs = 1'b1; b_wn = 1'b0; b_addr = A_PRD_H;  b_wd = PRD_M1[31:16]; end
      WR_CTRL: begin b_cs = 1'b1; b_wn = 1'b0; b_addr = A_CTRL;   b_wd = CTRL_START;    end
      CLR_STS: begin b_cs = 1'b1; b_wn = 1'b0; b_addr = A_STATUS; end
      SNAP_WR: begin b_cs = 1'b1; b_wn = 1'b0; b_addr = A_SNAP_L; end
      RD_L_A:  begin b_cs = 1'b1; b_addr = A_SNAP_L; end
      RD_H_A:  begin b_cs = 1'b1; b_addr = A_SNAP_H; end
      WR_STOP: begin b_cs = 1'b1; b_wn = 1'b0; b_addr = A_CTRL;   b_wd = CTRL_STOP;     end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      chipselect     <= 1'b0;
      write_n        <= 1'b1;
      address        <= 3'd0;
      writedata      <= 16'h0000;
      busy           <= 1'b0;
      tick_pulse     <= 1'b0;
      snapshot_valid <= 1'b0;
      tick_count     <= 32'd0;
      snapshot       <= 32'd0;
      snap_l         <= 16'h0000;
    end else begin
      state          <= nxt;
      chipselect     <= b_cs;
      write_n        <= b_wn;
      address        <= b_addr;
      writedata      <= b_wd;
      busy           <= (nxt != IDLE);
      tick_pulse     <= (nxt == TICK);
      snapshot_valid <= (nxt == TICK) && SNAPSHOT_EN;
      // The slave returns data during the wait state; sample it at the end of it.
      if (state == RD_L_W) snap_l   <= readdata;
      if (state == RD_H_W) snapshot <= {readdata, snap_l};
      // Count commits at the end of TICK; a clear in that same cycle leaves 1.
      if (tick_clear)         tick_count <= (state == TICK) ? 32'd1 : 32'd0;
      else if (state == TICK) tick_count <= tick_count + 32'd1;
    end
  end

endmodule
